rle_pack: RTL and testbench
===========================

// Module: rle_pack
// PURPOSE
//  Byte-lane packer downstream of rle_enc, upstream of sample memory.
//  Drops disabled channel groups (byte lanes) from each stream word and packs the enabled
//  bytes densely into full DW-bit words, so narrow captures (8/16/24-bit) fill memory fully.
//  Partial residue is emitted on an explicit flush at end of capture.
// PARAMETERS
//  DW  32     stream data width, multiple of 8
//  KW  DW/8   number of byte lanes (groups)
// PORTS
//  clk             input   1   system clock
//  rst             input   1   reset, asynchronous, active-high
//  disabledGroups  input   KW  1 = lane dropped; static while busy (cnt!=0 or sto_valid)
//  flush           input   1   pulse: emit residue bytes as a zero-padded word
//  sti_data        input   DW  input word, lane k = bits [8k+7:8k]
//  sti_valid       input   1   input word valid
//  sti_ready       output  1   input word accepted when sti_valid & sti_ready
//  sto_data        output  DW  packed output word
//  sto_keep        output  KW  valid byte lanes of sto_data (all ones except flush word)
//  sto_valid       output  1   output word valid; held with data stable until sto_ready
//  sto_ready       input   1   downstream accepts output word
// BEHAVIOUR
//  - Reset (async, any time): sto_valid=0, sto_data=0, sto_keep=0, residue buffer=0, cnt=0,
//    flush_pend=0; residue in flight is discarded. First cycle after release is normal.
//  - N = popcount(~disabledGroups), 0..KW. Enabled bytes are packed in ascending lane order.
//  - State: residue buffer buf (KW-1 bytes used), cnt = residue byte count, 0..KW-1.
//  - out_free = !sto_valid | sto_ready.  sti_ready = out_free & !flush_pend & !flush.
//  - On accept: comb = buf | (packed_N_bytes << 8*cnt); tot = cnt+N (width to hold 2KW-1).
//      tot >= KW : sto_data <= comb[DW-1:0], sto_keep <= all ones, sto_valid <= 1,
//                  buf <= comb >> DW, cnt <= tot-KW.
//      tot <  KW : buf <= comb, cnt <= tot; sto_valid cleared if sto_ready, else held.
//  - Latency: output word registered 1 cycle after the accepting input edge.
//  - Throughput: one input per cycle when sto_ready=1; N=KW with cnt=0 is a 1-cycle pipe.
//  - N=0: inputs accepted and discarded, no output, cnt unchanged.
//  - Flush: flush sets flush_pend (or acts immediately if out_free). When out_free & pending:
//      cnt>0 : sto_data <= buf zero-padded, sto_keep <= (1<<cnt)-1, sto_valid <= 1, cnt <= 0.
//      cnt=0 : no output word; pending cleared.
//    flush has priority over sti in the same cycle (sti_ready=0 that cycle).
//  - Backpressure: while sto_valid & !sto_ready, sti_ready=0; no data lost or duplicated.
//  - Changing disabledGroups while busy: result undefined (controller guarantees idle).
// TESTING
//  1 dG=0000, 256 words {4{i[7:0]}}, sto_ready=1 -> 256 identical words, keep=1111, 1-cycle lag.
//  2 dG=1110, inputs low bytes 01,02,03,04,05 -> one word 0x04030201; flush -> 0x00000005 keep 0001.
//  3 dG=1100, inputs 0x..2211,0x..4433,0x..6655 -> 0x44332211; flush -> 0x00006655 keep 0011.
//  4 dG=1000, 4 inputs 0x00CCBBAA x4 -> 3 words 0xAACCBBAA,0xBBAACCBB,0xCCBBAACC, cnt back to 0.
//  5 dG=1110, sto_ready=0 for 5 cycles mid-stream -> sti_ready=0, sto_data stable, no loss.
//  6 dG=1100, cnt=2 then rst pulse -> sto_valid=0 at once; post-reset flush emits nothing.
//  7 dG=1111, 10 inputs + flush -> sti_ready=1 throughout, sto_valid never asserted.

Source files
------------

// File: rtl/rle_pack.sv
// Byte-lane packer: drops disabled lanes from each stream word and packs the
// enabled bytes densely into full DW-bit words; residue leaves on flush.
module rle_pack #(
    parameter int DW = 32,
    parameter int KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] disabledGroups,
    input  logic          flush,
    input  logic [DW-1:0] sti_data,
    input  logic          sti_valid,
    output logic          sti_ready,
    output logic [DW-1:0] sto_data,
    output logic [KW-1:0] sto_keep,
    output logic          sto_valid,
    input  logic          sto_ready
);

    localparam int BW   = DW - 8;
    localparam int CW   = 2 * DW - 8;
    localparam int CNTW = $clog2(KW);
    localparam int TW   = $clog2(2 * KW);
    localparam int IW   = $clog2(KW + 1);

    logic [BW-1:0]   res_buf;
    logic [CNTW-1:0] cnt;
    logic            flush_pend;

    logic            out_free;
    logic            accept;
    logic            flush_act;
    logic [DW-1:0]   packed_w;
    logic [IW-1:0]   n_en;
    logic [CW-1:0]   comb_w;
    logic [TW-1:0]   tot;
    logic [KW-1:0]   flush_keep;

    assign out_free  = !sto_valid || sto_ready;
    assign sti_ready = out_free && !flush_pend && !flush;
    assign accept    = sti_valid && sti_ready;
    assign flush_act = out_free && (flush || flush_pend);

    // Compact enabled lanes toward lane 0, preserving ascending lane order.
    always_comb begin
        packed_w = '0;
        n_en     = '0;
        for (int k = 0; k < KW; k++) begin
            if (!disabledGroups[k]) begin
                packed_w[8*n_en +: 8] = sti_data[8*k +: 8];
                n_en = n_en + IW'(1);
            end
        end
    end

    always_comb begin
        comb_w = CW'(res_buf) | (CW'(packed_w) << (8 * cnt));
        tot    = TW'(cnt) + TW'(n_en);
        flush_keep = '0;
        for (int k = 0; k < KW; k++) begin
            flush_keep[k] = (CNTW'(k) < cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sto_valid  <= 1'b0;
            sto_data   <= '0;
            sto_keep   <= '0;
            res_buf    <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (flush_act) begin
            flush_pend <= 1'b0;
            if (cnt != '0) begin
                sto_data  <= DW'(res_buf);
                sto_keep  <= flush_keep;
                sto_valid <= 1'b1;
                cnt       <= '0;
                res_buf   <= '0;
            end else if (sto_ready) begin
                sto_valid <= 1'b0;
            end
        end else begin
            // Flush arriving while the output is stalled waits for the slot.
            if (flush) begin
                flush_pend <= 1'b1;
            end
            if (accept) begin
                if (tot >= TW'(KW)) begin
                    sto_data  <= comb_w[DW-1:0];
                    sto_keep  <= '1;
                    sto_valid <= 1'b1;
                    res_buf   <= comb_w[CW-1:DW];
                    cnt       <= CNTW'(tot - TW'(KW));
                end else begin
                    res_buf <= comb_w[BW-1:0];
                    cnt     <= CNTW'(tot);
                    if (sto_ready) begin
                        sto_valid <= 1'b0;
                    end
                end
            end else if (sto_ready) begin
                sto_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rle_pack.sv
// Bench for rle_pack: hand-computed vector table, reference byte-queue model,
// and a scoreboard that compares every transferred output word.
module tb_rle_pack;

    localparam int DW = 32;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] disabledGroups = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] sti_data = '0;
    logic          sti_valid = 1'b0;
    logic          sti_ready;
    logic [DW-1:0] sto_data;
    logic [KW-1:0] sto_keep;
    logic          sto_valid;
    logic          sto_ready = 1'b1;

    always #5 clk = ~clk;

    rle_pack #(.DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .disabledGroups (disabledGroups),
        .flush          (flush),
        .sti_data       (sti_data),
        .sti_valid      (sti_valid),
        .sti_ready      (sti_ready),
        .sto_data       (sto_data),
        .sto_keep       (sto_keep),
        .sto_valid      (sto_valid),
        .sto_ready      (sto_ready)
    );

    typedef struct {
        logic [3:0]  dg;
        logic        fl;
        logic [31:0] data;
        logic        ev;
        logic [35:0] exp_w;   // {keep, data}
    } vec_t;

    vec_t        tbl[$];
    logic [35:0] sb[$];
    logic [7:0]  mq[$];
    int          checks = 0;
    int          failures = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) sto_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_raw(input logic [3:0] dg, input logic [31:0] d);
        bit acc = 1'b0;
        disabledGroups = dg;
        sti_data  = d;
        sti_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = sti_ready;
            tick();
        end
        sti_valid = 1'b0;
        check("accept", 64'(acc), 64'd1);
    endtask

    task automatic model_word(input logic [3:0] dg, input logic [31:0] d);
        logic [31:0] w;
        for (int k = 0; k < KW; k++)
            if (!dg[k]) mq.push_back(d[8*k +: 8]);
        while (mq.size() >= KW) begin
            w = {mq[3], mq[2], mq[1], mq[0]};
            for (int k = 0; k < KW; k++) void'(mq.pop_front());
            sb.push_back({4'hF, w});
        end
    endtask

    task automatic drive_m(input logic [3:0] dg, input logic [31:0] d);
        drive_raw(dg, d);
        model_word(dg, d);
    endtask

    task automatic flush_raw();
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_sti", 64'(sti_ready), 64'd0);
        tick();
        flush = 1'b0;
    endtask

    task automatic flush_m();
        logic [31:0] w = '0;
        logic [3:0]  kp = '0;
        flush_raw();
        if (mq.size() > 0) begin
            for (int i = 0; i < mq.size(); i++) begin
                w[8*i +: 8] = mq[i];
                kp[i] = 1'b1;
            end
            sb.push_back({kp, w});
            mq.delete();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [3:0]  pats[7];
        logic [7:0]  b;
        logic [3:0]  dg;
        time         t0;
        int          nw;

        fork
            forever begin
                @(negedge clk);
                if (!rst && sto_valid && sto_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output got=%0h%08h expected=none at %0t",
                                 sto_keep, sto_data, $time);
                    end else begin
                        check("out_word", 64'({sto_keep, sto_data}), 64'(sb.pop_front()));
                    end
                end
            end
            begin
                #1_000_000;
                $display("FAIL global_timeout");
                $fatal(1, "timeout");
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(sto_valid), 64'd0);
        check("rst_data", 64'(sto_data), 64'd0);
        check("rst_keep", 64'(sto_keep), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sti_ready", 64'(sti_ready), 64'd1);
        tick();

        // All lanes enabled: 1-cycle pipe, full throughput
        t0 = $time;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            drive_m(4'b0000, {b, b, b, b});
            check("t1_latency_valid", 64'(sto_valid), 64'd1);
            check("t1_latency_data", 64'(sto_data), 64'({b, b, b, b}));
        end
        check("t1_throughput_cycles", 64'(($time - t0) / 10), 64'd256);
        drain();

        // Hand-computed packing vectors
        tbl.push_back('{4'b1110, 1'b0, 32'hDEADBE01, 1'b0, 36'h0});
        tbl.push_back('{4'b1110, 1'b0, 32'hCAFE0002, 1'b0, 36'h0});
        tbl.push_back('{4'b1110, 1'b0, 32'h12345603, 1'b0, 36'h0});
        tbl.push_back('{4'b1110, 1'b0, 32'h00000004, 1'b1, 36'hF_04030201});
        tbl.push_back('{4'b1110, 1'b0, 32'h77777705, 1'b0, 36'h0});
        tbl.push_back('{4'b1110, 1'b1, 32'h0,        1'b1, 36'h1_00000005});
        tbl.push_back('{4'b1100, 1'b0, 32'hFFEE2211, 1'b0, 36'h0});
        tbl.push_back('{4'b1100, 1'b0, 32'h77884433, 1'b1, 36'hF_44332211});
        tbl.push_back('{4'b1100, 1'b0, 32'h12346655, 1'b0, 36'h0});
        tbl.push_back('{4'b1100, 1'b1, 32'h0,        1'b1, 36'h3_00006655});
        tbl.push_back('{4'b1000, 1'b0, 32'h00CCBBAA, 1'b0, 36'h0});
        tbl.push_back('{4'b1000, 1'b0, 32'h00CCBBAA, 1'b1, 36'hF_AACCBBAA});
        tbl.push_back('{4'b1000, 1'b0, 32'h00CCBBAA, 1'b1, 36'hF_BBAACCBB});
        tbl.push_back('{4'b1000, 1'b0, 32'h00CCBBAA, 1'b1, 36'hF_CCBBAACC});
        tbl.push_back('{4'b1000, 1'b1, 32'h0,        1'b0, 36'h0});
        tbl.push_back('{4'b0101, 1'b0, 32'hAABBCCDD, 1'b0, 36'h0});
        tbl.push_back('{4'b0101, 1'b0, 32'h11223344, 1'b1, 36'hF_1133AACC});
        tbl.push_back('{4'b0110, 1'b0, 32'h44332211, 1'b0, 36'h0});
        tbl.push_back('{4'b0110, 1'b0, 32'h88776655, 1'b1, 36'hF_88554411});
        tbl.push_back('{4'b0000, 1'b0, 32'h89ABCDEF, 1'b1, 36'hF_89ABCDEF});
        foreach (tbl[i]) begin
            if (tbl[i].ev) sb.push_back(tbl[i].exp_w);
            if (tbl[i].fl) flush_raw();
            else drive_raw(tbl[i].dg, tbl[i].data);
        end
        drain();

        // Backpressure mid-stream
        for (int i = 0; i < 4; i++) drive_m(4'b1110, 32'h10 + 32'(i));
        sto_ready = 1'b0;
        disabledGroups = 4'b1110;
        sti_data  = 32'h14;
        sti_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_sti_ready_low", 64'(sti_ready), 64'd0);
            check("t5_valid_held", 64'(sto_valid), 64'd1);
            check("t5_data_stable", 64'(sto_data), 64'h13121110);
            tick();
        end
        sto_ready = 1'b1;
        sti_valid = 1'b0;
        for (int i = 4; i < 10; i++) drive_m(4'b1110, 32'h10 + 32'(i));
        flush_m();
        drain();

        // Reset with a held word and residue in flight
        drive_m(4'b1000, 32'h00333231);
        drive_m(4'b1000, 32'h00363534);
        sto_ready = 1'b0;
        @(negedge clk);
        check("t6_valid_before_rst", 64'(sto_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(sto_valid), 64'd0);
        check("t6_rst_data", 64'(sto_data), 64'd0);
        check("t6_rst_keep", 64'(sto_keep), 64'd0);
        check("t6_pending_words", 64'(sb.size()), 64'd1);
        sb.delete();
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sto_ready = 1'b1;
        flush_raw();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_flush_word", 64'(sto_valid), 64'd0);
            tick();
        end
        drive_m(4'b1100, 32'h1234BBAA);
        flush_m();
        drain();

        // All lanes disabled: inputs swallowed, no output
        disabledGroups = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            sti_data  = $urandom;
            sti_valid = 1'b1;
            @(negedge clk);
            check("t7_sti_ready", 64'(sti_ready), 64'd1);
            check("t7_no_valid", 64'(sto_valid), 64'd0);
            tick();
        end
        sti_valid = 1'b0;
        flush_raw();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t7_flush_no_valid", 64'(sto_valid), 64'd0);
            tick();
        end

        // Random segments with random downstream stalls
        pats = '{4'b0000, 4'b1110, 4'b1100, 4'b1000, 4'b0101, 4'b0110, 4'b1010};
        rand_ready = 1'b1;
        for (int s = 0; s < 7; s++) begin
            dg = pats[s];
            nw = $urandom_range(15, 30);
            for (int i = 0; i < nw; i++) drive_m(dg, $urandom);
            flush_m();
            drain();
        end
        rand_ready = 1'b0;
        sto_ready = 1'b1;
        repeat (3) tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
